// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller and the datapath muxes it steers:
// opcodes, functs, FSM states, instruction classes and every select encoding.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_NOP  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE_ALU = 4'd0,
    CLS_ORI       = 4'd1,
    CLS_LUI       = 4'd2,
    CLS_LW        = 4'd3,
    CLS_SW        = 4'd4,
    CLS_BEQ       = 4'd5,
    CLS_J         = 4'd6,
    CLS_JAL       = 4'd7,
    CLS_JR        = 4'd8,
    CLS_NOP       = 4'd9,
    CLS_ILLEGAL   = 4'd10
  } instr_class_t;

  localparam logic [1:0] M1_RT  = 2'd0;
  localparam logic [1:0] M1_RD  = 2'd1;
  localparam logic [1:0] M1_RA  = 2'd2;

  localparam logic [1:0] M2_ALU = 2'd0;
  localparam logic [1:0] M2_DM  = 2'd1;
  localparam logic [1:0] M2_PC4 = 2'd2;

  localparam logic       M3_RD2 = 1'b0;
  localparam logic       M3_EXT = 1'b1;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_JUMP = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;

  function automatic logic needs_mem(instr_class_t c);
    return (c == CLS_LW) || (c == CLS_SW);
  endfunction

  function automatic logic needs_wb(instr_class_t c);
    return (c == CLS_RTYPE_ALU) || (c == CLS_ORI) || (c == CLS_LUI) ||
           (c == CLS_LW) || (c == CLS_JAL);
  endfunction

  // Instructions that retire in EXEC, and the NPC mode they commit with.
  function automatic logic retires_in_exec(instr_class_t c);
    return (c == CLS_BEQ) || (c == CLS_J) || (c == CLS_JR) || (c == CLS_NOP);
  endfunction

  function automatic logic [2:0] exec_npc(instr_class_t c);
    case (c)
      CLS_BEQ: return NPC_BEQ;
      CLS_J:   return NPC_JUMP;
      CLS_JR:  return NPC_JR;
      default: return NPC_PC4;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct to instruction-class decoder for the multi-cycle controller.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] cls
);

  instr_class_t cls_d;

  always_comb begin
    cls_d = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADDU, FUNCT_SUBU: cls_d = CLS_RTYPE_ALU;
          FUNCT_JR:               cls_d = CLS_JR;
          FUNCT_NOP:              cls_d = CLS_NOP;
          default:                cls_d = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:  cls_d = CLS_ORI;
      OP_LUI:  cls_d = CLS_LUI;
      OP_LW:   cls_d = CLS_LW;
      OP_SW:   cls_d = CLS_SW;
      OP_BEQ:  cls_d = CLS_BEQ;
      OP_J:    cls_d = CLS_J;
      OP_JAL:  cls_d = CLS_JAL;
      default: cls_d = CLS_ILLEGAL;
    endcase
  end

  assign cls = cls_d;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with a
// memory-ready handshake. Define MULTICYCLE_CTRL_PERF_EN to add cycle/instruction counters.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_sel,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       rf_wr,
  output logic       dm_wr,
  output logic [1:0] m1_sel,
  output logic [1:0] m2_sel,
  output logic       m3_sel,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [2:0] npc_op,
  output logic [2:0] state,
  output logic       illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t       state_reg;
  logic [3:0]   cls_raw;
  instr_class_t cls;
  logic [2:0]   alu_d;
  logic [1:0]   ext_d;
  logic         m3_d;
  logic         zero_unused;

  // The branch condition is resolved inside the NPC; the controller only forwards npc_op.
  assign zero_unused = zero;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls_raw)
  );

  assign cls   = instr_class_t'(cls_raw);
  assign state = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_FETCH;
    end else begin
      case (state_reg)
        ST_FETCH:  if (mem_ready) state_reg <= ST_DECODE;
        ST_DECODE: state_reg <= (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          if (needs_mem(cls))     state_reg <= ST_MEM;
          else if (needs_wb(cls)) state_reg <= ST_WB;
          else                    state_reg <= ST_FETCH;
        end
        ST_MEM:    if (mem_ready) state_reg <= (cls == CLS_LW) ? ST_WB : ST_FETCH;
        ST_WB:     state_reg <= ST_FETCH;
        ST_TRAP:   state_reg <= ST_TRAP;
        default:   state_reg <= ST_FETCH;
      endcase
    end
  end

  // ALU/EXT/M3 stay driven from EXEC through WB: no ALU output register in the datapath.
  always_comb begin
    alu_d = ALU_ADD;
    ext_d = EXT_ZERO;
    m3_d  = M3_RD2;
    case (cls)
      CLS_RTYPE_ALU: alu_d = (funct == FUNCT_SUBU) ? ALU_SUB : ALU_ADD;
      CLS_ORI: begin
        alu_d = ALU_OR;
        m3_d  = M3_EXT;
      end
      CLS_LUI: begin
        ext_d = EXT_LUI;
        m3_d  = M3_EXT;
      end
      CLS_LW, CLS_SW: begin
        ext_d = EXT_SIGN;
        m3_d  = M3_EXT;
      end
      CLS_BEQ: alu_d = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    rf_wr   = 1'b0;
    dm_wr   = 1'b0;
    m1_sel  = M1_RT;
    m2_sel  = M2_ALU;
    m3_sel  = M3_RD2;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    npc_op  = NPC_PC4;
    illegal = 1'b0;
    // Gating on reset keeps the edge that asserts reset free of any strobe.
    if (!reset) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
        end
        ST_EXEC: begin
          alu_op = alu_d;
          ext_op = ext_d;
          m3_sel = m3_d;
          if (retires_in_exec(cls)) begin
            pc_wr  = 1'b1;
            npc_op = exec_npc(cls);
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          alu_op  = alu_d;
          ext_op  = ext_d;
          m3_sel  = m3_d;
          if (mem_ready && (cls == CLS_SW)) begin
            dm_wr = 1'b1;
            pc_wr = 1'b1;
          end
        end
        ST_WB: begin
          rf_wr  = 1'b1;
          pc_wr  = 1'b1;
          alu_op = alu_d;
          ext_op = ext_d;
          m3_sel = m3_d;
          case (cls)
            CLS_RTYPE_ALU: m1_sel = M1_RD;
            CLS_LW:        m2_sel = M2_DM;
            CLS_JAL: begin
              m1_sel = M1_RA;
              m2_sel = M2_PC4;
              npc_op = NPC_JUMP;
            end
            default: ;
          endcase
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_wr) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction phase model.
// Counter checks are compiled in when MULTICYCLE_CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_sel, ir_wr, pc_wr, rf_wr, dm_wr, m3_sel, illegal;
  logic [1:0] m1_sel, m2_sel, ext_op;
  logic [2:0] alu_op, npc_op, state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
  int exp_cycles = 0;
  int exp_instrs = 0;
`endif

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .ir_wr     (ir_wr),
    .pc_wr     (pc_wr),
    .rf_wr     (rf_wr),
    .dm_wr     (dm_wr),
    .m1_sel    (m1_sel),
    .m2_sel    (m2_sel),
    .m3_sel    (m3_sel),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .npc_op    (npc_op),
    .state     (state),
    .illegal   (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, sel, irw, pcw, rfw, dmw;
    logic [1:0] m1, m2;
    logic       m3;
    logic [1:0] ext;
    logic [2:0] alu, npc;
    logic       ill;
  } ovec_t;

  // What an instruction needs, read straight off the instruction table.
  typedef struct packed {
    logic       legal, mem, wb, is_sw;
    logic [2:0] alu;
    logic [1:0] ext;
    logic       m3;
    logic [1:0] m1, m2;
    logic [2:0] npc;
  } iprop_t;

  ovec_t obs;
  assign obs = {state, mem_req, mem_sel, ir_wr, pc_wr, rf_wr, dm_wr,
                m1_sel, m2_sel, m3_sel, ext_op, alu_op, npc_op, illegal};

  int n_checks = 0;
  int n_fail = 0;
  int pcw_seen = 0;
  int retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic iprop_t props(input logic [31:0] w);
    iprop_t p;
    logic [5:0] o, f;
    p = '0;
    p.legal = 1'b1;
    o = w[31:26];
    f = w[5:0];
    case (o)
      6'h00: begin
        case (f)
          6'h21: begin p.wb = 1'b1; p.m1 = 2'd1; end
          6'h23: begin p.wb = 1'b1; p.m1 = 2'd1; p.alu = 3'd1; end
          6'h08: p.npc = 3'd3;
          6'h00: p.npc = 3'd0;
          default: p.legal = 1'b0;
        endcase
      end
      6'h0D: begin p.wb = 1'b1; p.alu = 3'd2; p.ext = 2'd0; p.m3 = 1'b1; end
      6'h0F: begin p.wb = 1'b1; p.ext = 2'd2; p.m3 = 1'b1; end
      6'h23: begin p.mem = 1'b1; p.wb = 1'b1; p.ext = 2'd1; p.m3 = 1'b1; p.m2 = 2'd1; end
      6'h2B: begin p.mem = 1'b1; p.is_sw = 1'b1; p.ext = 2'd1; p.m3 = 1'b1; end
      6'h04: begin p.alu = 3'd1; p.npc = 3'd1; end
      6'h02: p.npc = 3'd2;
      6'h03: begin p.wb = 1'b1; p.m1 = 2'd2; p.m2 = 2'd2; p.npc = 3'd2; end
      default: p.legal = 1'b0;
    endcase
    return p;
  endfunction

  function automatic ovec_t alu_phase(input iprop_t p, input logic [2:0] st);
    ovec_t e;
    e = '0;
    e.st = st;
    e.alu = p.alu;
    e.ext = p.ext;
    e.m3 = p.m3;
    return e;
  endfunction

  // Called at posedge+1 with inputs already set; compares at the falling edge.
  task automatic step(input string tag, input ovec_t e);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    if (pc_wr) pcw_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    ovec_t e;
    e = '0;
    e.st = ST_FETCH;
    reset = 1'b1;
    #1;
    check("reset_async", 32'(obs), 32'(e));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_instr_cnt", instr_cnt, 32'd0);
    exp_instrs = 0;
`endif
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(obs), 32'(e));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // abort_mem: assert reset in the second MEM cycle of a memory instruction.
  task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                           input logic z, input bit abort_mem);
    iprop_t p;
    ovec_t  e;
    p = props(w);
    op = w[31:26];
    funct = w[5:0];
    zero = z;
    pcw_seen = 0;
    $display("instr %08h fetch_wait=%0d mem_wait=%0d zero=%0b legal=%0b",
             w, fw, mw, z, p.legal);
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      e = '0;
      e.st = ST_FETCH;
      e.req = 1'b1;
      e.irw = (i == fw);
      step("fetch", e);
    end
    mem_ready = 1'($urandom);
    e = '0;
    e.st = ST_DECODE;
    step("decode", e);
    if (!p.legal) return;
    mem_ready = 1'($urandom);
    e = alu_phase(p, ST_EXEC);
    if (!p.mem && !p.wb) begin
      e.pcw = 1'b1;
      e.npc = p.npc;
    end
    step("exec", e);
    if (p.mem) begin
      for (int i = 0; i <= mw; i++) begin
        if (abort_mem && i == 1) begin
          mem_ready = 1'b1;
          do_reset(2);
          check("abort_no_retire", 32'(pcw_seen), 32'd0);
          return;
        end
        mem_ready = (i == mw);
        e = alu_phase(p, ST_MEM);
        e.req = 1'b1;
        e.sel = 1'b1;
        if (i == mw && p.is_sw) begin
          e.dmw = 1'b1;
          e.pcw = 1'b1;
        end
        step("mem", e);
      end
    end
    if (p.wb) begin
      mem_ready = 1'($urandom);
      e = alu_phase(p, ST_WB);
      e.rfw = 1'b1;
      e.pcw = 1'b1;
      e.npc = p.npc;
      e.m1 = p.m1;
      e.m2 = p.m2;
      step("wb", e);
    end
    check("pc_wr_once", 32'(pcw_seen), 32'd1);
    retired++;
`ifdef MULTICYCLE_CTRL_PERF_EN
    exp_instrs++;
`endif
  endtask

  task automatic trap_and_recover(input logic [31:0] w, input int hold);
    ovec_t e;
    run_instr(w, $urandom_range(0, 2), 0, 1'b0, 1'b0);
    e = '0;
    e.st = ST_TRAP;
    e.ill = 1'b1;
    for (int i = 0; i < hold; i++) begin
      mem_ready = 1'($urandom);
      step("trap", e);
    end
    do_reset(1);
  endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
  always @(posedge clk or posedge reset) begin
    if (reset) exp_cycles <= 0;
    else       exp_cycles <= exp_cycles + 1;
  end
`endif

  logic [5:0] leg_op    [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
  logic [5:0] leg_funct [11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    logic [31:0] w;
    ovec_t e;
    int k;
    e = '0;
    e.st = ST_FETCH;
    #1;
    check("reset_state", 32'(obs), 32'(e));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(32'h00221821, 0, 0, 1'b0, 1'b0);   // addu $3,$1,$2
    run_instr(32'h8C040008, 0, 2, 1'b0, 1'b0);   // lw $4,8($0)
    run_instr(32'h10220003, 0, 0, 1'b1, 1'b0);   // beq taken
    run_instr(32'h10220003, 1, 0, 1'b0, 1'b0);   // beq not taken
    run_instr(32'h0C000010, 0, 0, 1'b0, 1'b0);   // jal
    run_instr(32'h00000000, 2, 0, 1'b0, 1'b0);   // nop
    trap_and_recover(32'hFC000000, 10);          // opcode 0x3F
    run_instr(32'hAC050004, 0, 3, 1'b0, 1'b1);   // sw, reset mid-MEM

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        w = $urandom;
        for (int t = 0; t < 64 && props(w).legal; t++) w = $urandom;
        if (!props(w).legal) trap_and_recover(w, $urandom_range(1, 4));
      end else begin
        k = $urandom_range(0, 10);
        w = $urandom;
        w[31:26] = leg_op[k];
        if (leg_op[k] == 6'h00) w[5:0] = leg_funct[k];
        if (k == 3) w = '0;
        run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
      end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    @(negedge clk);
    check("cycle_cnt", cycle_cnt, 32'(exp_cycles));
    check("instr_cnt", instr_cnt, 32'(exp_instrs));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
